// File: rtl/blit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// blit_pkg -- shared command/state types and screen defaults for the blitter
// Rev 1.0
// ---------------------------------------------------------------------------
package blit_pkg;

    localparam int BLIT_ADDR_W   = 20;
    localparam int BLIT_COORD_W  = 10;
    localparam int BLIT_PAL_W    = 2;
    localparam int BLIT_SCREEN_W = 640;
    localparam int BLIT_SCREEN_H = 480;

    typedef struct packed {
        logic [BLIT_ADDR_W-1:0]  src_addr;
        logic [BLIT_COORD_W-1:0] x;
        logic [BLIT_COORD_W-1:0] y;
        logic [BLIT_COORD_W-1:0] w;
        logic [BLIT_COORD_W-1:0] h;
        logic [BLIT_PAL_W-1:0]   palette;
        logic                    flip;
        logic                    key_en;
    } blit_cmd_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        FETCH   = 3'd2,
        WAIT    = 3'd3,
        WRITE   = 3'd4,
        ADVANCE = 3'd5
    } blit_state_t;

endpackage
`default_nettype wire

// File: rtl/blit_cmd_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// blit_cmd_fifo -- show-ahead synchronous command queue with level count
// Rev 1.0
// ---------------------------------------------------------------------------
module blit_cmd_fifo
    import blit_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = blit_cmd_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  T                       din_i,
    output T                       dout_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (level_q == LVL_FULL);
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the head slot in the same cycle, so a full queue may still accept.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (PW+1)'(1);
                2'b01:   level_q <= level_q - (PW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/blit_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// blit_engine -- batched sprite blitter with colour key, h-flip and clipping
// Rev 1.0
// ---------------------------------------------------------------------------
module blit_engine
    import blit_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int COORD_W    = 10,
    parameter int PAL_W      = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int SCREEN_W   = BLIT_SCREEN_W,
    parameter int SCREEN_H   = BLIT_SCREEN_H
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDR_W-1:0]           cmd_src_addr,
    input  logic [COORD_W-1:0]          cmd_x,
    input  logic [COORD_W-1:0]          cmd_y,
    input  logic [COORD_W-1:0]          cmd_w,
    input  logic [COORD_W-1:0]          cmd_h,
    input  logic [PAL_W-1:0]            cmd_palette,
    input  logic                        cmd_flip,
    input  logic                        cmd_key_en,
    input  logic [DATA_W-1:0]           key_color,
    input  logic                        current_frame,
    output logic                        src_rd,
    output logic [ADDR_W-1:0]           src_addr,
    input  logic                        src_valid,
    input  logic [DATA_W-1:0]           src_data,
    output logic                        program_write,
    output logic [COORD_W-1:0]          program_x,
    output logic [COORD_W-1:0]          program_y,
    output logic [DATA_W-1:0]           program_data,
    output logic [PAL_W-1:0]            palette_index,
    output logic                        engine_busy,
    output logic                        engine_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    typedef struct packed {
        logic [ADDR_W-1:0]  src_addr;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [PAL_W-1:0]   palette;
        logic               flip;
        logic               key_en;
    } cmd_t;

    localparam logic [COORD_W:0]   CLIP_X = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0]   CLIP_Y = (COORD_W+1)'(SCREEN_H);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

    cmd_t               cmd_in;
    cmd_t               head;
    cmd_t               cmd_q;
    blit_state_t        state_q;
    logic [COORD_W-1:0] c_q;
    logic [COORD_W-1:0] r_q;
    logic [COORD_W-1:0] px_q;
    logic [COORD_W-1:0] py_q;
    logic               clip_q;
    logic [DATA_W-1:0]  pdata_q;
    logic               src_rd_q;
    logic               wr_q;
    logic               done_q;
    logic               armed_q;
    logic               frame_q;
    logic               frame_vld_q;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               frame_edge;
    logic               last_col;
    logic               last_row;

    logic [COORD_W-1:0] la_x;
    logic [COORD_W-1:0] la_y;
    logic [COORD_W-1:0] la_w;
    logic               la_flip;
    logic [COORD_W-1:0] la_c_d;
    logic [COORD_W-1:0] la_r_d;
    logic [COORD_W-1:0] la_col;
    logic [COORD_W:0]   la_dx_d;
    logic [COORD_W:0]   la_dy_d;
    logic               la_clip_d;

    assign cmd_in = '{src_addr: cmd_src_addr, x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h,
                      palette: cmd_palette, flip: cmd_flip, key_en: cmd_key_en};

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = (state_q == LOAD);

    blit_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (cmd_t)
    ) u_fifo (
        .clk_i   (clk_clk),
        .rst_i   (reset_reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (cmd_in),
        .dout_o  (head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign frame_edge = frame_vld_q && (current_frame != frame_q);
    assign last_col   = (c_q == cmd_q.w - ONE);
    assign last_row   = (r_q == cmd_q.h - ONE);

    // Destination of the pixel about to be fetched, computed one state early so
    // that src_rd can be a registered output already valid in FETCH.
    always_comb begin
        la_x    = cmd_q.x;
        la_y    = cmd_q.y;
        la_w    = cmd_q.w;
        la_flip = cmd_q.flip;
        la_c_d  = last_col ? '0 : c_q + ONE;
        la_r_d  = last_col ? r_q + ONE : r_q;
        if (state_q == LOAD) begin
            la_x    = head.x;
            la_y    = head.y;
            la_w    = head.w;
            la_flip = head.flip;
            la_c_d  = '0;
            la_r_d  = '0;
        end
        la_col    = la_flip ? (la_w - ONE - la_c_d) : la_c_d;
        la_dx_d   = {1'b0, la_x} + {1'b0, la_col};
        la_dy_d   = {1'b0, la_y} + {1'b0, la_r_d};
        la_clip_d = (la_dx_d >= CLIP_X) || (la_dy_d >= CLIP_Y);
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            c_q         <= '0;
            r_q         <= '0;
            px_q        <= '0;
            py_q        <= '0;
            clip_q      <= 1'b0;
            pdata_q     <= '0;
            src_rd_q    <= 1'b0;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;
            armed_q     <= 1'b0;
            frame_q     <= 1'b0;
            frame_vld_q <= 1'b0;
        end else begin
            frame_q     <= current_frame;
            frame_vld_q <= 1'b1;
            src_rd_q    <= 1'b0;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;
            if (frame_edge) begin
                armed_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (armed_q) begin
                        if (!fifo_empty) begin
                            state_q <= LOAD;
                        end else begin
                            done_q  <= 1'b1;
                            armed_q <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    cmd_q <= head;
                    c_q   <= '0;
                    r_q   <= '0;
                    if (head.w == '0 || head.h == '0) begin
                        state_q <= IDLE;
                    end else begin
                        state_q  <= FETCH;
                        clip_q   <= la_clip_d;
                        px_q     <= la_dx_d[COORD_W-1:0];
                        py_q     <= la_dy_d[COORD_W-1:0];
                        src_rd_q <= !la_clip_d;
                    end
                end
                FETCH: begin
                    state_q <= clip_q ? ADVANCE : WAIT;
                end
                WAIT: begin
                    if (src_valid) begin
                        if (cmd_q.key_en && (src_data == key_color)) begin
                            state_q <= ADVANCE;
                        end else begin
                            state_q <= WRITE;
                            wr_q    <= 1'b1;
                            pdata_q <= src_data;
                        end
                    end
                end
                WRITE: begin
                    state_q <= ADVANCE;
                end
                ADVANCE: begin
                    // Row-major walk keeps the source address a plain +1 per pixel.
                    cmd_q.src_addr <= cmd_q.src_addr + ADDR_W'(1);
                    c_q            <= la_c_d;
                    r_q            <= la_r_d;
                    if (last_col && last_row) begin
                        state_q <= IDLE;
                    end else begin
                        state_q  <= FETCH;
                        clip_q   <= la_clip_d;
                        px_q     <= la_dx_d[COORD_W-1:0];
                        py_q     <= la_dy_d[COORD_W-1:0];
                        src_rd_q <= !la_clip_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign src_rd        = src_rd_q;
    assign src_addr      = cmd_q.src_addr;
    assign program_write = wr_q;
    assign program_x     = px_q;
    assign program_y     = py_q;
    assign program_data  = pdata_q;
    assign palette_index = cmd_q.palette;
    assign engine_busy   = armed_q;
    assign engine_done   = done_q;

endmodule
`default_nettype wire
